// File: rtl/squash_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : squash_ctrl_pkg
//  Description : Shared types and constants for the squash input controller:
//                controller state encoding, default timing parameters and the
//                button bit positions as they appear on ui_in[3:0].
//  Revision    : 1.0 - initial release
// ============================================================================
package squash_ctrl_pkg;

  // Controller state: normal play, paused, or attract/demo mode.
  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_PAUSED = 2'd1,
    ST_DEMO   = 2'd2
  } ctrl_state_t;

  // Default timing parameters, in video frames.
  localparam int DEF_DEBOUNCE_FRAMES   = 2;
  localparam int DEF_IDLE_FRAMES       = 1800;
  localparam int DEF_DEMO_SWEEP_FRAMES = 32;

  // Button positions, matching the ui_in bit order.
  localparam int NUM_BTNS     = 4;
  localparam int BTN_PAUSE    = 0;
  localparam int BTN_NEW_GAME = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_UP       = 3;

  // Bits needed to hold 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/squash_input_ctrl_button.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : One raw button: 2-flop synchronizer, frame-sampled debounce
//                counter and debounced level. 'level' already reflects the
//                decision taken on the current frame tick so the controller
//                can act on it in the same clock; 'press' marks a 0->1 flip of
//                the debounced level and is only ever high during a tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import squash_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic tick,
  output logic level,
  output logic press
);

  localparam int            CW       = cnt_width(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_q;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          flip;

  // Two-stage synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // The level flips on the tick that completes the run of disagreeing samples.
  assign differs = (sync_q2 != level_q);
  assign flip    = tick && differs && (cnt == CNT_LAST);
  assign level   = flip ? ~level_q : level_q;
  assign press   = flip && !level_q;

  // Count consecutive disagreeing frame samples; any agreeing sample restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (tick) begin
      if (!differs || (cnt == CNT_LAST)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_q <= level;
    end
  end

endmodule
`default_nettype wire

// File: rtl/squash_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : squash_input_ctrl
//  Description : Control sequencer between the raw player buttons and the
//                solo_squash core. Debounces the buttons once per frame,
//                toggles pause on each pause press, issues a one-frame
//                new-game pulse, and after a long idle period drives an
//                attract mode that sweeps the paddle up and down.
//  Revision    : 1.0 - initial release
// ============================================================================
module squash_input_ctrl
  import squash_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES   = DEF_DEBOUNCE_FRAMES,
  parameter int IDLE_FRAMES       = DEF_IDLE_FRAMES,
  parameter int DEMO_SWEEP_FRAMES = DEF_DEMO_SWEEP_FRAMES,
  parameter bit VSYNC_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_new_game,
  input  logic btn_down,
  input  logic btn_up,
  input  logic vsync,
  output logic pause_n,
  output logic new_game_n,
  output logic down_key_n,
  output logic up_key_n,
  output logic paused,
  output logic demo_active
);

  localparam int            IW         = cnt_width(IDLE_FRAMES);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_FRAMES);
  localparam int            SW         = cnt_width(DEMO_SWEEP_FRAMES - 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(DEMO_SWEEP_FRAMES - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] lvl;
  logic [NUM_BTNS-1:0] prs;

  logic          vsync_act;
  logic          vsync_act_d;
  logic          tick;

  ctrl_state_t   state;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_next;
  logic [SW-1:0] sweep_cnt;
  logic          sweep_down;
  logic          sweep_down_next;
  logic          mask_up;
  logic          mask_down;
  logic          mask_up_next;
  logic          mask_down_next;
  logic          eff_up;
  logic          eff_down;
  logic          activity;
  logic          any_press;

  assign btn_raw = {btn_up, btn_down, btn_new_game, btn_pause};

  // ---------------------------------------------------------------- buttons
  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[i]),
      .tick    (tick),
      .level   (lvl[i]),
      .press   (prs[i])
    );
  end

  // ------------------------------------------------------------- frame tick
  assign vsync_act = VSYNC_ACTIVE_LOW ? ~vsync : vsync;

  // One-clock tick registered after vsync becomes active. The history flop
  // resets to "active" so a vsync already active at reset release is not
  // mistaken for a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_act_d <= 1'b1;
      tick        <= 1'b0;
    end else begin
      vsync_act_d <= vsync_act;
      tick        <= vsync_act && !vsync_act_d;
    end
  end

  // ------------------------------------------------------ per-tick helpers
  assign activity  = |lvl;
  assign any_press = |prs;
  assign idle_next = activity ? '0
                   : (idle_cnt == IDLE_MAX) ? idle_cnt
                   : idle_cnt + IW'(1);

  // A paddle button still held from the press that ended demo mode stays
  // suppressed until it is released.
  assign mask_up_next   = mask_up   && lvl[BTN_UP];
  assign mask_down_next = mask_down && lvl[BTN_DOWN];
  assign eff_up         = lvl[BTN_UP]   && !mask_up_next;
  assign eff_down       = lvl[BTN_DOWN] && !mask_down_next;

  assign sweep_down_next = (sweep_cnt == SWEEP_LAST) ? ~sweep_down : sweep_down;

  // Controller state machine with registered outputs, advanced on ticks only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_PLAY;
      idle_cnt    <= '0;
      sweep_cnt   <= '0;
      sweep_down  <= 1'b0;
      mask_up     <= 1'b0;
      mask_down   <= 1'b0;
      pause_n     <= 1'b1;
      new_game_n  <= 1'b1;
      down_key_n  <= 1'b1;
      up_key_n    <= 1'b1;
      paused      <= 1'b0;
      demo_active <= 1'b0;
    end else if (tick) begin
      // The new-game pulse lasts from its decision tick to the next tick.
      new_game_n <= 1'b1;
      case (state)
        ST_DEMO: begin
          if (any_press) begin
            // Leave demo; the waking press only starts a new game.
            state       <= ST_PLAY;
            new_game_n  <= 1'b0;
            idle_cnt    <= '0;
            demo_active <= 1'b0;
            mask_up     <= lvl[BTN_UP];
            mask_down   <= lvl[BTN_DOWN];
            up_key_n    <= 1'b1;
            down_key_n  <= 1'b1;
          end else begin
            sweep_cnt  <= (sweep_cnt == SWEEP_LAST) ? '0 : sweep_cnt + SW'(1);
            sweep_down <= sweep_down_next;
            up_key_n   <= sweep_down_next;
            down_key_n <= ~sweep_down_next;
          end
        end
        default: begin
          mask_up    <= mask_up_next;
          mask_down  <= mask_down_next;
          up_key_n   <= ~(eff_up && !eff_down);
          down_key_n <= ~(eff_down && !eff_up);
          if (prs[BTN_NEW_GAME]) begin
            // New game wins over a simultaneous pause press.
            state      <= ST_PLAY;
            new_game_n <= 1'b0;
            idle_cnt   <= '0;
            paused     <= 1'b0;
            pause_n    <= 1'b1;
          end else if (idle_next == IDLE_MAX) begin
            state       <= ST_DEMO;
            idle_cnt    <= '0;
            sweep_cnt   <= '0;
            sweep_down  <= 1'b0;
            demo_active <= 1'b1;
            paused      <= 1'b0;
            pause_n     <= 1'b1;
            up_key_n    <= 1'b0;
            down_key_n  <= 1'b1;
          end else if (prs[BTN_PAUSE]) begin
            if (state == ST_PLAY) begin
              state    <= ST_PAUSED;
              idle_cnt <= idle_next;
              paused   <= 1'b1;
              pause_n  <= 1'b0;
            end else begin
              state    <= ST_PLAY;
              idle_cnt <= '0;
              paused   <= 1'b0;
              pause_n  <= 1'b1;
            end
          end else begin
            idle_cnt <= idle_next;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_squash_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_squash_input_ctrl
//  Description : Self-checking bench for squash_input_ctrl. Each frame applies
//                a button pattern, produces one vsync, and compares outputs
//                against a frame-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_squash_input_ctrl;

  localparam int DEB       = 2;
  localparam int IDLE      = 8;
  localparam int SWEEP     = 4;
  localparam int FRAME_CYC = 12;
  localparam int M_PLAY    = 0;
  localparam int M_PAUSED  = 1;
  localparam int M_DEMO    = 2;
  localparam logic [5:0] RST_VEC = 6'b111100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_pause = 1'b0;
  logic btn_new_game = 1'b0;
  logic btn_down = 1'b0;
  logic btn_up = 1'b0;
  logic vsync = 1'b1;
  logic pause_n, new_game_n, down_key_n, up_key_n, paused, demo_active;

  int n_checks = 0;
  int n_fail = 0;
  int ng_low = 0;

  // Model state (frame level).
  logic [3:0] m_deb;
  int         m_cnt [4];
  int         m_st;
  int         m_idle;
  int         m_demo_frames;
  bit         m_mask_up;
  bit         m_mask_dn;
  bit         m_pulse;

  always #5 clk = ~clk;

  squash_input_ctrl #(
    .DEBOUNCE_FRAMES   (DEB),
    .IDLE_FRAMES       (IDLE),
    .DEMO_SWEEP_FRAMES (SWEEP),
    .VSYNC_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_pause    (btn_pause),
    .btn_new_game (btn_new_game),
    .btn_down     (btn_down),
    .btn_up       (btn_up),
    .vsync        (vsync),
    .pause_n      (pause_n),
    .new_game_n   (new_game_n),
    .down_key_n   (down_key_n),
    .up_key_n     (up_key_n),
    .paused       (paused),
    .demo_active  (demo_active)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] act_vec();
    return {pause_n, new_game_n, down_key_n, up_key_n, paused, demo_active};
  endfunction

  function automatic logic [5:0] exp_vec();
    logic pn, ngn, dn, un, p, d;
    bit   eu, ed;
    p   = (m_st == M_PAUSED);
    d   = (m_st == M_DEMO);
    pn  = !p;
    ngn = !m_pulse;
    if (d) begin
      un = ((m_demo_frames / SWEEP) % 2) != 0;
      dn = !un;
    end else begin
      eu = m_deb[3] && !m_mask_up;
      ed = m_deb[2] && !m_mask_dn;
      un = !(eu && !ed);
      dn = !(ed && !eu);
    end
    return {pn, ngn, dn, un, p, d};
  endfunction

  task automatic model_reset();
    m_deb = 4'b0000;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_st = M_PLAY;
    m_idle = 0;
    m_demo_frames = 0;
    m_mask_up = 0;
    m_mask_dn = 0;
    m_pulse = 0;
  endtask

  // One frame tick of the behavioural rules; b = {up, down, new_game, pause}.
  task automatic model_tick(input logic [3:0] b);
    logic [3:0] prs;
    bit act;
    prs = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (b[i] != m_deb[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] >= DEB) begin
          m_deb[i] = b[i];
          m_cnt[i] = 0;
          if (b[i]) prs[i] = 1'b1;
        end
      end else begin
        m_cnt[i] = 0;
      end
    end
    act = (m_deb != 4'b0000);
    m_pulse = 0;
    if (m_st == M_DEMO) begin
      if (prs != 4'b0000) begin
        m_st = M_PLAY;
        m_pulse = 1;
        m_idle = 0;
        m_mask_up = m_deb[3];
        m_mask_dn = m_deb[2];
      end else begin
        m_demo_frames++;
      end
    end else begin
      m_mask_up = m_mask_up && m_deb[3];
      m_mask_dn = m_mask_dn && m_deb[2];
      if (prs[1]) begin
        m_st = M_PLAY;
        m_pulse = 1;
        m_idle = 0;
      end else begin
        m_idle = act ? 0 : ((m_idle < IDLE) ? m_idle + 1 : IDLE);
        if (m_idle >= IDLE) begin
          m_st = M_DEMO;
          m_idle = 0;
          m_demo_frames = 0;
        end else if (prs[0]) begin
          m_st = (m_st == M_PLAY) ? M_PAUSED : M_PLAY;
        end
      end
    end
  endtask

  // Apply buttons for one frame with a single vsync pulse; starts and ends at a negedge.
  task automatic run_frame(input logic [3:0] b);
    {btn_up, btn_down, btn_new_game, btn_pause} = b;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c == 5) vsync = 1'b0;
      if (c == 7) vsync = 1'b1;
      @(negedge clk);
      if (new_game_n === 1'b0) ng_low++;
    end
    model_tick(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {btn_up, btn_down, btn_new_game, btn_pause} = 4'b0000;
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      {btn_up, btn_down, btn_new_game, btn_pause} = 4'($urandom);
      vsync = 1'($urandom);
      @(negedge clk);
    end
    n_checks++;
    if (act_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", act_vec(), RST_VEC);
    end
    do_reset();
    for (int f = 0; f < 7; f++) begin
      run_frame(4'b0000);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
    end
    n_checks++;
    if (act_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_still_play: got %b want %b", act_vec(), RST_VEC);
    end
  endtask

  task automatic test_pause_toggle();
    logic [3:0] seq [8] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000,
                            4'b0001, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    for (int f = 0; f < 8; f++) begin
      run_frame(seq[f]);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL pause_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
      if (f == 1) begin
        n_checks++;
        if (paused !== 1'b1 || pause_n !== 1'b0) begin
          n_fail++;
          $display("FAIL pause_on: got paused=%b pause_n=%b want 1/0", paused, pause_n);
        end
      end
      if (f == 5) begin
        n_checks++;
        if (paused !== 1'b0 || pause_n !== 1'b1) begin
          n_fail++;
          $display("FAIL pause_off: got paused=%b pause_n=%b want 0/1", paused, pause_n);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] seq [8] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000,
                            4'b1100, 4'b1100, 4'b0000, 4'b0000};
    do_reset();
    for (int f = 0; f < 8; f++) begin
      run_frame(seq[f]);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
      if (f == 1) begin
        n_checks++;
        if (up_key_n !== 1'b1) begin
          n_fail++;
          $display("FAIL glitch_blip: got up_key_n=%b want 1", up_key_n);
        end
      end
      if (f == 3) begin
        n_checks++;
        if (up_key_n !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch_hold: got up_key_n=%b want 0", up_key_n);
        end
      end
      if (f == 5) begin
        n_checks++;
        if ({up_key_n, down_key_n} !== 2'b11) begin
          n_fail++;
          $display("FAIL glitch_both: got up/down=%b want 11", {up_key_n, down_key_n});
        end
      end
    end
  endtask

  task automatic test_new_game_over_pause();
    logic [3:0] seq [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0000};
    do_reset();
    for (int f = 0; f < 4; f++) begin
      run_frame(seq[f]);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL ngp_setup_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
    end
    run_frame(4'b0011);
    ng_low = 0;
    run_frame(4'b0011);
    n_checks++;
    if ({paused, pause_n, new_game_n} !== 3'b010) begin
      n_fail++;
      $display("FAIL ngp_decision: got paused/pause_n/new_game_n=%b want 010",
               {paused, pause_n, new_game_n});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL ngp_model: got %b want %b", act_vec(), exp_vec());
    end
    run_frame(4'b0000);
    n_checks++;
    if (new_game_n !== 1'b1 || ng_low != FRAME_CYC) begin
      n_fail++;
      $display("FAIL ngp_pulse_len: got new_game_n=%b low_cycles=%0d want 1 and %0d",
               new_game_n, ng_low, FRAME_CYC);
    end
  endtask

  task automatic test_demo();
    int guard;
    do_reset();
    guard = 0;
    while (m_st != M_DEMO && guard < 20) begin
      run_frame(4'b0000);
      guard++;
    end
    n_checks++;
    if (demo_active !== 1'b1 || guard != IDLE) begin
      n_fail++;
      $display("FAIL demo_entry: got demo_active=%b after %0d frames want 1 after %0d",
               demo_active, guard, IDLE);
    end
    for (int f = 0; f < 12; f++) begin
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL demo_sweep_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
      run_frame(4'b0000);
    end
  endtask

  task automatic test_demo_exit_reset();
    run_frame(4'b0100);
    run_frame(4'b0100);
    n_checks++;
    if ({demo_active, new_game_n, down_key_n} !== 3'b001) begin
      n_fail++;
      $display("FAIL demo_exit: got demo/new_game_n/down_key_n=%b want 001",
               {demo_active, new_game_n, down_key_n});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL demo_exit_model: got %b want %b", act_vec(), exp_vec());
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (new_game_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_pulse: got new_game_n=%b want 0", new_game_n);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_vec() !== RST_VEC) begin
      n_fail++;
      $display("FAIL async_reset: got %b want %b", act_vec(), RST_VEC);
    end
    @(negedge clk);
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(4'b0000);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL post_reset_f%0d: got %b want %b", f, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    do_reset();
    b = 4'b0000;
    for (int f = 0; f < 80; f++) begin
      if (f >= 30 && f < 45) b = 4'b0000;
      else if ($urandom_range(2) == 0) b = 4'($urandom);
      run_frame(b);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_f%0d: btn=%b got %b want %b", f, b, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_pause_toggle();
    test_glitch();
    test_new_game_over_pause();
    test_demo();
    test_demo_exit_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/squash_input_ctrl.md
# squash_input_ctrl

Control sequencer between the raw player buttons and the `solo_squash` game core's active-low control inputs. Synchronizes and frame-rate debounces four buttons, turns the pause button into a press-to-toggle pause level, and stretches new-game into a one-frame pulse. After a period of idle it runs an attract/demo mode that sweeps the paddle automatically. Instantiated in the TinyTapeout top between `ui_in[3:0]` and the game core.

## Interface
- `DEBOUNCE_FRAMES`, default 2: consecutive identical frame samples required to change a debounced button state (≥1).
- `IDLE_FRAMES`, default 1800: frames without button activity before entering DEMO (about 30 s at 60 Hz).
- `DEMO_SWEEP_FRAMES`, default 32: frames per paddle sweep direction in DEMO.
- `VSYNC_ACTIVE_LOW`, default 1: polarity of the `vsync` input.
- `clk`  in  1: pixel clock, 25.175 MHz nominal; the only clock.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `btn_pause`, `btn_new_game`, `btn_down`, `btn_up`  in  1 each: raw buttons, active-high, asynchronous to `clk`.
- `vsync`  in  1: vsync from the game core, in the `clk` domain.
- `pause_n`, `new_game_n`, `down_key_n`, `up_key_n`  out  1 each: to the core, active-low, registered.
- `paused`  out  1: high while in PAUSED.
- `demo_active`  out  1: high while in DEMO.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer.
- **Frame tick:** a 1-clk pulse on the cycle after `vsync` goes from inactive to active level.
- **Debounce:**
  - Each synchronized button is sampled only on a frame tick.
  - The debounced state flips after `DEBOUNCE_FRAMES` consecutive ticks whose sample differs from the current state.
  - Any agreeing sample clears the count.
  - A "press" is a 0→1 transition of the debounced state.
- **Activity:** any debounced button high on a tick, or any press.
- **State machine (PLAY, PAUSED, DEMO), evaluated on ticks only:**
  - PLAY + pause press → PAUSED.
  - PAUSED + pause press → PLAY.
  - PLAY or PAUSED + idle count reaches `IDLE_FRAMES` → DEMO. Pause is cleared.
  - DEMO + any press → PLAY, and a new-game pulse is issued. The triggering press is otherwise consumed.
  - new_game press in PLAY or PAUSED → PLAY plus a new-game pulse. This takes priority over a pause press on the same tick.
- **Idle counter:**
  - Saturating; width clog2(`IDLE_FRAMES`+1).
  - Increments on ticks without activity in PLAY and PAUSED.
  - Clears on activity and on entry to PLAY.
  - Held at 0 in DEMO.
- **New-game pulse:** `new_game_n` goes low for exactly one frame, from the decision tick until the next tick.
- **Paddle keys, outside DEMO:**
  - `up_key_n` = ~debounced up and `down_key_n` = ~debounced down.
  - If both are debounced high, both outputs go high (neither key asserted).
- **Paddle keys in DEMO:**
  - A sweep counter alternates the direction every `DEMO_SWEEP_FRAMES` ticks, starting with up.
  - The active direction's key is low and the other is high.
- **Pause output:** `pause_n` = ~(state == PAUSED). It is held low as a level for the whole PAUSED period.

## Timing
- **Reset values:** all `*_n` outputs = 1, `paused` = 0, `demo_active` = 0, state PLAY. All debounce, idle and sweep counters are 0; synchronizers are 0.
- **Output update:** all outputs change only in the clk after a frame tick, a registered update one cycle after the tick.
- **Button latency:** from a stable raw edge to the output, 2 clk of synchronizer, then the `DEBOUNCE_FRAMES`-th subsequent tick, plus 1 clk.
- **Mid-operation reset:** `rst_n` low at any time returns all outputs to reset values asynchronously, including mid new-game pulse and in DEMO. No pulse is resumed after release.
- **Missing vsync:** outputs hold and no state advances.

## Structure
- **Package `squash_ctrl_pkg`:**
  - State enum (PLAY, PAUSED, DEMO).
  - Default parameter constants.
  - Button index constants (PAUSE=0, NEW_GAME=1, DOWN=2, UP=3), matching the `ui_in` bit order.
- **Sub-module `button_debounce`:**
  - Contains the 2-flop synchronizer, the frame-sampled counter, and the debounced level plus press-pulse outputs.
  - Instantiated four times.

## Test plan
All scenarios use `DEBOUNCE_FRAMES`=2, `IDLE_FRAMES`=8, `DEMO_SWEEP_FRAMES`=4, and a short synthetic vsync period.
- **Reset:** hold `rst_n`=0 with random buttons → all `*_n` = 1, `paused`=0, `demo_active`=0. Deassert, then drive no buttons for 7 ticks → still PLAY.
- **Pause toggle:** press `btn_pause` across 2 ticks, then release for 2 ticks → `pause_n`=0 and `paused`=1 one clk after the 2nd tick. Press again → `pause_n` returns to 1.
- **Glitch rejection:** a 1-tick `btn_up` blip → `up_key_n` stays 1. Hold it for 2 ticks → `up_key_n`=0. Hold both up and down → both outputs are 1.
- **New game over pause:** press new_game and pause simultaneously while in PAUSED → state PLAY, `paused`=0, `new_game_n` low for exactly one frame.
- **Demo entry and sweep:** 8 idle ticks → `demo_active`=1. `up_key_n`=0 for 4 ticks, then `down_key_n`=0 for 4 ticks, repeating.
- **Demo exit and reset mid-pulse:**
  - A `btn_down` press during DEMO → PLAY, `demo_active`=0, a one-frame `new_game_n` pulse, and `down_key_n` not asserted by that press.
  - Asserting `rst_n`=0 mid-pulse → `new_game_n`=1 immediately.
